// File: rtl/tdc_meas_ctrl.sv
// Delay-line TDC measurement controller.
// Measures the time between synchronised start and stop edges as a coarse clock-cycle count
// plus a fine value (the popcount of the delay-line thermometer code), then buffers each
// {timeout, coarse, fine} record in a small FIFO that is read out one byte at a time.
module tdc_meas_ctrl #(
   parameter int unsigned N_TAPS     = 16,
   parameter int unsigned COARSE_W   = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned FINE_W    = $clog2(N_TAPS + 1),
   localparam int unsigned REC_W     = 1 + COARSE_W + FINE_W,
   localparam int unsigned N_BYTES   = (REC_W + 7) / 8,
   localparam int unsigned SEL_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm,
   input  logic               mode,
   input  logic               clr,
   input  logic               start,
   input  logic               stop,
   input  logic [N_TAPS-1:0]  tap_code,
   input  logic               rd_en,
   input  logic [SEL_W-1:0]   byte_sel,
   output logic [7:0]         dout,
   output logic               busy,
   output logic               fifo_empty,
   output logic               fifo_full,
   output logic               overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned PAD_W = 8 * N_BYTES;

   typedef enum logic [1:0] {StIdle, StArmed, StMeas, StWrite} state_e;

   state_e               state_q, state_d;
   logic [COARSE_W-1:0]  coarse_q, coarse_d;
   logic [REC_W-1:0]     rec_q, rec_d;
   logic [FINE_W-1:0]    fine;

   logic start_s1_q, start_s2_q, start_s3_q;
   logic stop_s1_q, stop_s2_q, stop_s3_q;
   logic start_rise, stop_rise;

   logic [REC_W-1:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic                 overflow_q;
   logic                 push_req, push_ok, pop, drop;
   logic [PAD_W-1:0]     head_pad;

   // Two-flop synchronisers plus an edge flop; identical latency on both paths cancels out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         start_s3_q <= 1'b0;
         stop_s1_q  <= 1'b0;
         stop_s2_q  <= 1'b0;
         stop_s3_q  <= 1'b0;
      end else begin
         start_s1_q <= start;
         start_s2_q <= start_s1_q;
         start_s3_q <= start_s2_q;
         stop_s1_q  <= stop;
         stop_s2_q  <= stop_s1_q;
         stop_s3_q  <= stop_s2_q;
      end
   end

   assign start_rise = start_s2_q & ~start_s3_q;
   assign stop_rise  = stop_s2_q & ~stop_s3_q;

   // Fine value: popcount tolerates bubbles in the thermometer code.
   always_comb begin
      fine = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         fine = fine + FINE_W'(tap_code[i]);
      end
   end

   // FSM state, coarse counter and captured record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         coarse_q <= '0;
         rec_q    <= '0;
      end else begin
         state_q  <= state_d;
         coarse_q <= coarse_d;
         rec_q    <= rec_d;
      end
   end

   // FSM next state; clr overrides everything and discards any in-flight measurement.
   always_comb begin
      state_d  = state_q;
      coarse_d = coarse_q;
      rec_d    = rec_q;
      if (clr) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arm) state_d = StArmed;
            end
            StArmed: begin
               if (start_rise) begin
                  state_d  = StMeas;
                  coarse_d = '0;
               end
            end
            StMeas: begin
               if (stop_rise) begin
                  rec_d   = {1'b0, coarse_q, fine};
                  state_d = StWrite;
               end else if (coarse_q == '1) begin
                  rec_d   = {1'b1, coarse_q, {FINE_W{1'b0}}};
                  state_d = StWrite;
               end else begin
                  coarse_d = coarse_q + COARSE_W'(1);
               end
            end
            StWrite: begin
               state_d = mode ? StArmed : StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign busy       = (state_q == StArmed) || (state_q == StMeas);
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign overflow   = overflow_q;

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign push_req = (state_q == StWrite) && !clr;
   assign pop      = rd_en && !fifo_empty && !clr;
   assign push_ok  = push_req && (!fifo_full || pop);
   assign drop     = push_req && !push_ok;

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clr) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
         if (drop) overflow_q <= 1'b1;
      end
   end

   // Record storage; contents are only visible while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rec_q;
   end

   // Byte-selected view of the head record, zero when empty or out of range.
   always_comb begin
      head_pad = PAD_W'(mem_q[rd_ptr_q]);
      dout     = '0;
      if (!fifo_empty) begin
         for (int b = 0; b < N_BYTES; b++) begin
            if (byte_sel == SEL_W'(b)) dout = head_pad[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl at default parameters (14-bit records, two bytes).
module tb_tdc_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm, mode, clr, start, stop, rd_en;
   logic [15:0] tap_code;
   logic [0:0]  byte_sel;
   logic [7:0]  dout;
   logic        busy, fifo_empty, fifo_full, overflow;

   int n_checks = 0;
   int n_fail   = 0;

   tdc_meas_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .mode       (mode),
      .clr        (clr),
      .start      (start),
      .stop       (stop),
      .tap_code   (tap_code),
      .rd_en      (rd_en),
      .byte_sel   (byte_sel),
      .dout       (dout),
      .busy       (busy),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Record at default widths: {timeout, coarse[7:0], fine[4:0]}.
   function automatic logic [15:0] rec(input logic to, input logic [7:0] c, input logic [4:0] f);
      return {2'b00, to, c, f};
   endfunction

   task automatic check_head(input string tag, input logic [15:0] exp);
      logic [15:0] r;
      r = exp;
      byte_sel = 1'b0;
      #1;
      check({tag, "_b0"}, {8'h00, dout}, {8'h00, r[7:0]});
      byte_sel = 1'b1;
      #1;
      check({tag, "_b1"}, {8'h00, dout}, {8'h00, r[15:8]});
      byte_sel = 1'b0;
   endtask

   task automatic arm_pulse();
      @(negedge clk); arm = 1'b1;
      @(negedge clk); arm = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk); rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
   endtask

   task automatic clr_pulse();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   // Stop rises k cycles after start; the record is pushed well before the task returns.
   task automatic do_meas(input int k);
      @(negedge clk); start = 1'b1;
      repeat (k) @(negedge clk);
      stop = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; arm = 1'b0; mode = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0;
      rd_en = 1'b0; tap_code = '0; byte_sel = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_empty", {15'd0, fifo_empty}, 16'd1);
      check("rst_full", {15'd0, fifo_full}, 16'd0);
      check("rst_ovf", {15'd0, overflow}, 16'd0);
      check("rst_dout", {8'h00, dout}, 16'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single shot, k=10, eight taps set
      tap_code = 16'h00FF; mode = 1'b0;
      arm_pulse();
      check("t1_armed", {15'd0, busy}, 16'd1);
      do_meas(10);
      check("t1_idle", {15'd0, busy}, 16'd0);
      check("t1_nonempty", {15'd0, fifo_empty}, 16'd0);
      check_head("t1_rec", 16'h0128);
      pop_one();
      check("t1_empty", {15'd0, fifo_empty}, 16'd1);
      #1 check("t1_dout_empty", {8'h00, dout}, 16'd0);

      // 2/3: continuous fill, then a dropped fifth record
      tap_code = 16'hFFFF; mode = 1'b1;
      arm_pulse();
      do_meas(3); do_meas(5); do_meas(7); do_meas(2);
      check("t2_full", {15'd0, fifo_full}, 16'd1);
      check("t2_rearmed", {15'd0, busy}, 16'd1);
      check("t2_no_ovf", {15'd0, overflow}, 16'd0);
      do_meas(4);
      check("t3_ovf", {15'd0, overflow}, 16'd1);
      check("t3_full", {15'd0, fifo_full}, 16'd1);
      check_head("t2_pop0", rec(1'b0, 8'd2, 5'd16));
      pop_one();
      check("t2_not_full", {15'd0, fifo_full}, 16'd0);
      check_head("t2_pop1", rec(1'b0, 8'd4, 5'd16));
      pop_one();
      check_head("t2_pop2", rec(1'b0, 8'd6, 5'd16));
      pop_one();
      check_head("t2_pop3", rec(1'b0, 8'd1, 5'd16));
      pop_one();
      check("t2_empty", {15'd0, fifo_empty}, 16'd1);
      pop_one();
      check("t2_pop_empty_ignored", {15'd0, fifo_empty}, 16'd1);
      check("t3_ovf_sticky", {15'd0, overflow}, 16'd1);
      clr_pulse();
      check("t3_clr_ovf", {15'd0, overflow}, 16'd0);
      check("t3_clr_idle", {15'd0, busy}, 16'd0);
      check("t3_clr_empty", {15'd0, fifo_empty}, 16'd1);

      // 4: timeout after coarse saturates
      mode = 1'b0;
      arm_pulse();
      @(negedge clk); start = 1'b1;
      repeat (270) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("t4_idle", {15'd0, busy}, 16'd0);
      check_head("t4_timeout", 16'h3FE0);
      pop_one();
      check("t4_empty", {15'd0, fifo_empty}, 16'd1);

      // 5: push into a full FIFO while the head is popped in the WRITE cycle
      mode = 1'b1;
      arm_pulse();
      do_meas(1); do_meas(2); do_meas(3); do_meas(4);
      check("t5_full", {15'd0, fifo_full}, 16'd1);
      @(negedge clk); start = 1'b1;
      repeat (5) @(negedge clk);
      stop = 1'b1;
      repeat (3) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk); rd_en = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b0; stop = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_no_ovf", {15'd0, overflow}, 16'd0);
      check("t5_still_full", {15'd0, fifo_full}, 16'd1);
      check_head("t5_head1", rec(1'b0, 8'd1, 5'd16));
      pop_one();
      check_head("t5_head2", rec(1'b0, 8'd2, 5'd16));
      pop_one();
      check_head("t5_head3", rec(1'b0, 8'd3, 5'd16));
      pop_one();
      check_head("t5_head4", rec(1'b0, 8'd4, 5'd16));
      pop_one();
      check("t5_empty", {15'd0, fifo_empty}, 16'd1);
      clr_pulse();
      mode = 1'b0;

      // 6: reset in the middle of a measurement, then a k=1 measurement
      tap_code = 16'h003F;
      arm_pulse();
      do_meas(2);
      check_head("t6_pre", rec(1'b0, 8'd1, 5'd6));
      arm_pulse();
      @(negedge clk); start = 1'b1;
      repeat (8) @(negedge clk);
      check("t6_meas_busy", {15'd0, busy}, 16'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", {15'd0, busy}, 16'd0);
      check("t6_rst_empty", {15'd0, fifo_empty}, 16'd1);
      check("t6_rst_full", {15'd0, fifo_full}, 16'd0);
      check("t6_rst_ovf", {15'd0, overflow}, 16'd0);
      check("t6_rst_dout", {8'h00, dout}, 16'd0);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_post_empty", {15'd0, fifo_empty}, 16'd1);
      arm_pulse();
      do_meas(1);
      check("t6_k1_idle", {15'd0, busy}, 16'd0);
      check_head("t6_k1", rec(1'b0, 8'd0, 5'd6));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Parametrised measurement controller for the delay-line TDC. It arms on command, runs a coarse clk-cycle counter between synchronised start and stop edges, and encodes the delay-line thermometer tap code into a fine value. Each {timeout, coarse, fine} record is pushed into a small result FIFO, which an 8-bit byte-selectable port reads out. It sits between the TDC delay line and the chip's 8-bit output pins, and adds single-shot and continuous modes, timeout, overflow and buffering.

Parameters:
N_TAPS, 16, delay-line taps in tap_code; FINE_W = clog2(N_TAPS+1) (5 at default)
COARSE_W, 8, coarse counter width
FIFO_DEPTH, 4, result records buffered; power of two, >=2
REC_W (derived), 1+COARSE_W+FINE_W (14 at default); N_BYTES = ceil(REC_W/8); SEL_W = max(1, clog2(N_BYTES))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  level; in IDLE, moves the FSM to ARMED
mode  in  1  0 = single-shot (return to IDLE after one record), 1 = continuous (re-arm)
clr  in  1  synchronous: flush FIFO, clear overflow, force FSM to IDLE
start  in  1  asynchronous start pulse/level
stop  in  1  asynchronous stop pulse/level
tap_code  in  N_TAPS  thermometer code from the delay line
rd_en  in  1  pop the head record (1-cycle strobe)
byte_sel  in  SEL_W  byte of head record presented on dout
dout  out  8  selected byte of head record, zero-padded
busy  out  1  FSM in ARMED or MEAS
fifo_empty  out  1  no records stored
fifo_full  out  1  FIFO_DEPTH records stored
overflow  out  1  sticky: a record was dropped

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, coarse=0, FIFO pointers/count=0, overflow=0, sync flops=0. Outputs: dout=0, busy=0, fifo_empty=1, fifo_full=0.
- start and stop each pass a 2-flop synchroniser plus an edge flop. start_rise = s2 & ~s3 (same for stop). Both paths have equal latency, so the offset cancels.
- FSM states: IDLE, ARMED, MEAS, WRITE.
  - IDLE: arm=1 -> ARMED.
  - ARMED: start_rise -> MEAS with coarse<=0. A stop_rise in ARMED, or in the same cycle as start_rise, is ignored.
  - MEAS: each cycle without stop_rise, coarse<=coarse+1.
    - stop_rise k cycles after start_rise (k>=1): capture coarse=k-1, fine=popcount(tap_code) sampled at that edge (bubble-tolerant), timeout=0 -> WRITE.
    - coarse reaching all-ones without stop_rise: capture coarse=all-ones, fine=0, timeout=1 -> WRITE.
    - start_rise during MEAS is ignored.
  - WRITE (1 cycle): push the record, then mode=1 -> ARMED, mode=0 -> IDLE. mode is sampled in WRITE.
- Record layout: bit REC_W-1 = timeout, then coarse, then fine in the LSBs. Byte b = record[8b+7:8b], zero-padded above REC_W-1.
- Push in WRITE:
  - Accepted if count<FIFO_DEPTH, or if rd_en pops in the same cycle (count unchanged).
  - Otherwise the record is dropped and overflow<=1.
  - overflow clears only on clr or reset.
- Pop: rd_en with fifo_empty=1 is ignored. Simultaneous push and pop updates both pointers.
- dout is combinational from the head entry and byte_sel. dout=0 when empty or when byte_sel>=N_BYTES.
- clr: takes precedence over all other events that cycle. FSM->IDLE, count=0, overflow=0. An in-flight measurement is discarded.
- Pointers wrap modulo FIFO_DEPTH. fifo_full and fifo_empty are derived from count, which is (clog2(FIFO_DEPTH)+1) bits.
- Reset asserted mid-measurement aborts everything immediately. No record is written.

Test Plan:
1. Reset, arm=1, mode=0; start_rise, then stop_rise 10 cycles later with tap_code=16'h00FF -> one record {0, coarse=9, fine=8}. byte_sel=0 gives dout=0x28; byte_sel=1 gives dout=0x01. FSM returns to IDLE, busy=0.
2. mode=1, four start/stop pairs with k=3,5,7,2 and tap_code=0xFFFF -> fifo_full=1. Pops return coarse 2,4,6,1 with fine=16 each, in order.
3. mode=1, FIFO full, fifth measurement completes with no rd_en -> record dropped, overflow=1, count stays 4. clr -> fifo_empty=1, overflow=0, FSM IDLE.
4. Start with no stop for 255 cycles -> record {timeout=1, coarse=0xFF, fine=0}; dout byte1 = 0x3F, byte0 = 0xE0.
5. FIFO full and rd_en asserted in the WRITE cycle -> push accepted, no overflow, count stays 4, head advances.
6. rst_n deasserted low during MEAS -> all outputs at reset values immediately. After release, arm plus a measurement with k=1 yields coarse=0.
